mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the external memory bus between up to NREQ internal masters: refresh, object processor, GPU/blitter and the external CPU bus interface.
- Issues a registered one-hot grant and switches owners only at memory-cycle boundaries, marked by ack.
- Inserts turnaround cycles so the tristate drivers of rw, mreq and w[] never overlap.
- Fixed priority (lowest index wins), with wait counters that promote starved requesters.

Parameters:
- NREQ, 4, number of requesters; index 0 has the highest priority.
- TURN, 1, dead cycles with no grant between owners (range 1..3).
- MAXWAIT, 15, cycles a pending requester waits before it becomes urgent.
- WAITW, 4, width of each wait counter; must satisfy 2^WAITW-1 >= MAXWAIT.

Ports:
- clk_0  in  1  system clock; all state changes on the rising edge.
- resetl  in  1  asynchronous, active-low reset.
- req  in  NREQ  bus requests; level, held for as long as the requester wants the bus.
- hold  in  1  from the current owner; blocks preemption (read-modify-write, burst).
- ack  in  1  memory controller: the current cycle completes this clock.
- gnt  out  NREQ  one-hot grant or all zero; registered.
- owner  out  2  encoded index of the granted requester; 0 when there is no grant.
- owner_valid  out  1  OR of gnt.
- turnaround  out  1  high during RELEASE cycles.
- urgent  out  NREQ  wait counter saturated, per requester.

Behaviour:
- Reset (asynchronous, on resetl low): gnt=0, owner=0, owner_valid=0, turnaround=0, urgent=0, all wait counters 0, state IDLE. Asserting reset mid-ownership drops gnt immediately.
- States: IDLE, OWNED, RELEASE.
- Winner function:
  - If any req[i] has urgent[i] set, the winner is the lowest such index.
  - Otherwise the winner is the lowest index with req[i].
  - With no req, there is no winner.
- IDLE:
  - If any req is high at edge N, gnt[winner]=1 after edge N (one-cycle latency) and the state goes to OWNED.
  - If no req is high, stay in IDLE.
- OWNED, owner k:
  - If req[k]=0, go to RELEASE. This takes effect regardless of ack or hold.
  - Preemption: when ack=1, hold=0 and some j≠k has req[j] with (urgent[j] or j<k), go to RELEASE.
  - Otherwise keep gnt[k].
  - If ack=1 and req[k] falls in the same cycle, go to RELEASE once, not twice.
  - ack=0 never permits a preemption.
- RELEASE:
  - gnt=0 and turnaround=1 for exactly TURN cycles.
  - On the edge that ends the last RELEASE cycle, evaluate the winner from the current req. If there is one, gnt[winner]=1 and the state goes to OWNED; otherwise go to IDLE.
  - The previous owner may win again if it is still the winner.
  - A req that drops during RELEASE is not granted.
- Wait counter i:
  - Cleared when req[i]=0 or gnt[i]=1.
  - Otherwise it increments by 1 per clock, saturating at MAXWAIT.
  - urgent[i] = (count==MAXWAIT), registered.
  - The owner's counter is always 0, so the owner is never urgent.
- ack in IDLE or RELEASE is ignored.
- hold outside OWNED is ignored.
- gnt is never multi-hot. owner and owner_valid are consistent with gnt on every cycle.

Test Plan:
- Reset, then req=0001 at edge 3 → gnt=0001 and owner_valid=1 after edge 3. Drop req at edge 10 → gnt=0 for 1 cycle (turnaround=1), then IDLE.
- Owner 3 active, req=1010 asserted with ack=0 → no switch. Pulse ack=1 with hold=0 → RELEASE for TURN cycles, then gnt=0010.
- Same as previous but hold=1 during ack → gnt stays 1000. hold=0 at the next ack → switch to 0010.
- Owner 0 holds req continuously with ack pulsing; req[2] held → after 15 waiting cycles urgent[2]=1. At the next ack, 0 is preempted, then gnt=0100 and urgent[2] clears.
- Four requesters released simultaneously from IDLE, req=1111 → gnt=0001. Owner 0 drops req → after RELEASE, gnt=0010. The sequence continues in index order.
- resetl low while gnt=0100 mid-cycle → gnt=0 and urgent=0 immediately. After reset release with req=0100, the grant is re-issued one edge later.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: fixed priority with starvation promotion, registered one-hot grant,
// owner changes only at ack boundaries with TURN dead cycles between owners.
module mem_bus_arbiter #(
   parameter int NREQ    = 4,
   parameter int TURN    = 1,
   parameter int MAXWAIT = 15,
   parameter int WAITW   = 4
) (
   input  logic            clk_0,
   input  logic            resetl,
   input  logic [NREQ-1:0] req,
   input  logic            hold,
   input  logic            ack,
   output logic [NREQ-1:0] gnt,
   output logic [1:0]      owner,
   output logic            owner_valid,
   output logic            turnaround,
   output logic [NREQ-1:0] urgent
);

   // state   | meaning
   // IDLE    | no owner, grant the winner on the next edge
   // OWNED   | gnt[owner] held until release or preemption at ack
   // RELEASE | TURN dead cycles, drivers tristated, then re-arbitrate

   typedef enum logic [1:0] {IDLE, OWNED, RELEASE} state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        turn_q, turn_d;
   logic [NREQ-1:0]   urgent_q;
   logic [WAITW-1:0]  wait_q [NREQ];
   logic [WAITW-1:0]  wait_d [NREQ];
   logic              win_valid;
   logic [1:0]        win_idx;
   logic              any_urg;
   logic              preempt;

   // Urgent requesters form their own priority tier above the plain one.
   always_comb begin
      any_urg   = |(req & urgent_q);
      win_valid = |req;
      win_idx   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (any_urg ? (req[i] && urgent_q[i]) : req[i]) win_idx = 2'(i);
      end
   end

   always_comb begin
      preempt = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (req[j] && (2'(j) != owner_q) && (urgent_q[j] || (2'(j) < owner_q))) preempt = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      turn_d  = turn_q;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d = OWNED;
               gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
               owner_d = win_idx;
            end
         end
         OWNED: begin
            if (!req[owner_q] || (ack && !hold && preempt)) begin
               state_d = RELEASE;
               gnt_d   = '0;
               owner_d = '0;
               turn_d  = 2'(TURN - 1);
            end
         end
         RELEASE: begin
            if (turn_q == 2'd0) begin
               if (win_valid) begin
                  state_d = OWNED;
                  gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                  owner_d = win_idx;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               turn_d = turn_q - 2'd1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
         end
      endcase
   end

   // Clearing on the incoming grant too keeps the owner's counter at 0 from its first cycle.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         if (!req[i] || gnt_q[i] || gnt_d[i]) wait_d[i] = '0;
         else if (wait_q[i] == WAITW'(MAXWAIT)) wait_d[i] = wait_q[i];
         else wait_d[i] = wait_q[i] + 1'b1;
      end
   end

   always_ff @(posedge clk_0 or negedge resetl) begin
      if (!resetl) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         owner_q  <= '0;
         turn_q   <= '0;
         urgent_q <= '0;
         for (int i = 0; i < NREQ; i++) wait_q[i] <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         turn_q  <= turn_d;
         for (int i = 0; i < NREQ; i++) begin
            wait_q[i]   <= wait_d[i];
            urgent_q[i] <= (wait_d[i] == WAITW'(MAXWAIT));
         end
      end
   end

   assign gnt         = gnt_q;
   assign owner       = owner_q;
   assign owner_valid = |gnt_q;
   assign turnaround  = (state_q == RELEASE);
   assign urgent      = urgent_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with an owner/queue-level reference model
// checked every cycle, plus literal expectations at key points.
module tb_mem_bus_arbiter;
   localparam int NREQ    = 4;
   localparam int TURN    = 1;
   localparam int MAXWAIT = 15;

   logic            clk_0 = 1'b0;
   logic            resetl;
   logic [NREQ-1:0] req;
   logic            hold;
   logic            ack;
   logic [NREQ-1:0] gnt;
   logic [1:0]      owner;
   logic            owner_valid;
   logic            turnaround;
   logic [NREQ-1:0] urgent;

   int tests  = 0;
   int errors = 0;

   mem_bus_arbiter #(.NREQ(NREQ), .TURN(TURN), .MAXWAIT(MAXWAIT), .WAITW(4)) dut (
      .clk_0(clk_0), .resetl(resetl), .req(req), .hold(hold), .ack(ack),
      .gnt(gnt), .owner(owner), .owner_valid(owner_valid),
      .turnaround(turnaround), .urgent(urgent)
   );

   always #5 clk_0 = ~clk_0;

   // Model: who owns the bus (-1 none), dead cycles left, and per-requester wait ages.
   int m_own;
   int m_dead;
   int m_age [NREQ];

   function automatic int pick_winner();
      int w;
      w = -1;
      for (int i = 0; i < NREQ; i++)
         if (w < 0 && req[i] && m_age[i] == MAXWAIT) w = i;
      for (int i = 0; i < NREQ; i++)
         if (w < 0 && req[i]) w = i;
      return w;
   endfunction

   always @(posedge clk_0 or negedge resetl) begin
      if (!resetl) begin
         m_own  = -1;
         m_dead = 0;
         for (int i = 0; i < NREQ; i++) m_age[i] = 0;
      end else begin
         int w, prev, nxt;
         bit challenger;
         w    = pick_winner();
         prev = m_own;
         nxt  = m_own;
         if (m_dead > 0) begin
            if (m_dead == 1) nxt = w;
            m_dead = m_dead - 1;
         end else if (m_own < 0) begin
            nxt = w;
         end else begin
            challenger = 1'b0;
            for (int j = 0; j < NREQ; j++)
               if (j != m_own && req[j] && (m_age[j] == MAXWAIT || j < m_own)) challenger = 1'b1;
            if (!req[m_own] || (ack && !hold && challenger)) begin
               nxt    = -1;
               m_dead = TURN;
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] || prev == i || nxt == i) m_age[i] = 0;
            else if (m_age[i] < MAXWAIT) m_age[i] = m_age[i] + 1;
         end
         m_own = nxt;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk_0) begin
      if (resetl === 1'b1) begin
         logic [NREQ-1:0] e_gnt, e_urg;
         e_gnt = '0;
         e_urg = '0;
         if (m_own >= 0) e_gnt[m_own] = 1'b1;
         for (int i = 0; i < NREQ; i++) e_urg[i] = (m_age[i] == MAXWAIT);
         check("model_gnt", 32'(gnt), 32'(e_gnt));
         check("model_owner", 32'(owner), (m_own >= 0) ? 32'(m_own) : 32'd0);
         check("model_owner_valid", 32'(owner_valid), 32'(m_own >= 0));
         check("model_turnaround", 32'(turnaround), 32'(m_dead > 0));
         check("model_urgent", 32'(urgent), 32'(e_urg));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk_0);
   endtask

   task automatic go_idle();
      req = '0; ack = 1'b0; hold = 1'b0;
      step(3);
      check("idle_gnt", 32'(gnt), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, errors so far %0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      resetl = 1'b0; req = '0; ack = 1'b0; hold = 1'b0;
      step(2);
      check("reset_gnt", 32'(gnt), 32'h0);
      check("reset_owner_valid", 32'(owner_valid), 32'h0);
      check("reset_urgent", 32'(urgent), 32'h0);
      resetl = 1'b1;
      step(2);

      // single requester, drop -> one dead cycle -> idle
      req = 4'b0001;
      step(1);
      check("s1_gnt", 32'(gnt), 32'h1);
      check("s1_owner_valid", 32'(owner_valid), 32'h1);
      step(6);
      req = 4'b0000;
      step(1);
      check("s1_rel_gnt", 32'(gnt), 32'h0);
      check("s1_rel_turn", 32'(turnaround), 32'h1);
      step(1);
      check("s1_idle_turn", 32'(turnaround), 32'h0);
      go_idle();

      // higher-priority request waits for ack
      req = 4'b1000;
      step(1);
      check("s2_gnt3", 32'(gnt), 32'h8);
      check("s2_owner3", 32'(owner), 32'h3);
      req = 4'b1010; ack = 1'b0;
      step(3);
      check("s2_noack_gnt", 32'(gnt), 32'h8);
      ack = 1'b1;
      step(1);
      check("s2_rel_gnt", 32'(gnt), 32'h0);
      check("s2_rel_turn", 32'(turnaround), 32'h1);
      ack = 1'b0;
      step(1);
      check("s2_gnt1", 32'(gnt), 32'h2);
      check("s2_owner1", 32'(owner), 32'h1);
      go_idle();

      // hold blocks preemption at ack
      req = 4'b1000;
      step(1);
      req = 4'b1010; ack = 1'b1; hold = 1'b1;
      step(1);
      check("s3_hold_gnt", 32'(gnt), 32'h8);
      ack = 1'b0; hold = 1'b0;
      step(1);
      check("s3_noack_gnt", 32'(gnt), 32'h8);
      ack = 1'b1;
      step(1);
      check("s3_rel_gnt", 32'(gnt), 32'h0);
      ack = 1'b0;
      step(1);
      check("s3_gnt1", 32'(gnt), 32'h2);
      go_idle();

      // starvation promotion of requester 2 past owner 0
      req = 4'b0001;
      step(1);
      req = 4'b0101;
      for (int i = 0; i < 14; i++) begin
         ack = i[0];
         step(1);
      end
      check("s4_not_urgent_yet", 32'(urgent), 32'h0);
      check("s4_still_gnt0", 32'(gnt), 32'h1);
      ack = 1'b0;
      step(1);
      check("s4_urgent2", 32'(urgent), 32'h4);
      ack = 1'b1;
      step(1);
      check("s4_preempt_gnt", 32'(gnt), 32'h0);
      ack = 1'b0;
      step(1);
      check("s4_gnt2", 32'(gnt), 32'h4);
      check("s4_urgent_clear", 32'(urgent), 32'h0);
      go_idle();

      // all four at once, served in index order as each drops
      req = 4'b1111;
      step(1);
      check("s5_gnt0", 32'(gnt), 32'h1);
      req = 4'b1110;
      step(2);
      check("s5_gnt1", 32'(gnt), 32'h2);
      req = 4'b1100;
      step(2);
      check("s5_gnt2", 32'(gnt), 32'h4);
      req = 4'b1000;
      step(2);
      check("s5_gnt3", 32'(gnt), 32'h8);
      check("s5_owner3", 32'(owner), 32'h3);
      go_idle();

      // asynchronous reset mid-ownership
      req = 4'b1100;
      step(1);
      check("s6_gnt2", 32'(gnt), 32'h4);
      step(15);
      check("s6_urgent3", 32'(urgent), 32'h8);
      #2 resetl = 1'b0;
      #1;
      check("s6_async_gnt", 32'(gnt), 32'h0);
      check("s6_async_urgent", 32'(urgent), 32'h0);
      check("s6_async_owner_valid", 32'(owner_valid), 32'h0);
      @(negedge clk_0);
      resetl = 1'b1;
      req = 4'b0100;
      step(1);
      check("s6_regrant", 32'(gnt), 32'h4);
      go_idle();

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
